dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL be the word-address width of the shared data memory (256 words).
REQ-002 Parameter DATA_W, default 32, SHALL be the data word width.
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 m0_req_i / m0_we_i  in  1 / 1  SHALL be the port-0 (core LSU) request valid and write-select.
REQ-006 m0_addr_i / m0_wdata_i  in  ADDR_W / DATA_W  SHALL be the port-0 address and write data.
REQ-007 m0_gnt_o / m0_rvalid_o / m0_rdata_o  out  1 / 1 / DATA_W  SHALL be the port-0 grant, read-response valid and read data.
REQ-008 m1_* SHALL be an identical set of signals for port 1 (debug/DMA).
REQ-009 clr_start_i  in  1  SHALL be a single-cycle request to zero-fill the whole memory.
REQ-010 clr_busy_o / clr_done_o  out  1 / 1  SHALL be the clear-in-progress flag and the one-cycle completion pulse.
REQ-011 mem_addr_o / mem_wr_dt_o / mem_wr_en_o  out  ADDR_W / DATA_W / 1  SHALL drive the memory address, write data and write enable.
REQ-012 mem_rd_dt_i  in  DATA_W  SHALL be the memory's combinational read data for mem_addr_o.

Function
REQ-013 The block SHALL issue at most one memory access per cycle: port 0, port 1, or a clear write.
REQ-014 Grants SHALL be combinational in the request cycle: mx_gnt_o = mx_req_i AND port x selected.
REQ-015 Port arbitration SHALL be round-robin with a 1-bit priority pointer; port 0 SHALL have priority after reset.
REQ-016 After a cycle granting port k, the pointer SHALL point to the other port; it SHALL hold when no port is granted.
REQ-017 A requester SHALL keep req/we/addr/wdata stable until granted; an ungranted request has no effect.
REQ-018 Granted write: mem_wr_en_o=1, mem_addr_o/mem_wr_dt_o from that port, same cycle; no rvalid is generated.
REQ-019 Granted read: mem_wr_en_o=0; in the next cycle mx_rvalid_o=1 for exactly one cycle and mx_rdata_o holds mem_rd_dt_i registered at grant (1-cycle latency).
REQ-020 mx_rdata_o SHALL hold its last value while rvalid is low.
REQ-021 Back-to-back reads on one port SHALL each get a response (throughput 1/cycle when uncontended).
REQ-022 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR on clr_start_i (counter set to 0); clr_start_i SHALL be ignored in CLEAR.
REQ-023 In CLEAR, a zero write to the counter address SHALL be issued only in cycles with no port request; ports always win over clear.
REQ-024 The counter SHALL advance only on an issued clear write; the write to address 2^ADDR_W-1 SHALL return the FSM to IDLE, pulse clr_done_o in the following cycle, and wrap the counter to 0.
REQ-025 clr_busy_o SHALL be 1 exactly while in CLEAR.
REQ-026 Port accesses during CLEAR SHALL be serviced normally; a port write to a not-yet-cleared address may be overwritten by the clear.
REQ-027 When nothing is issued, mem_wr_en_o SHALL be 0 and mem_addr_o/mem_wr_dt_o SHALL be 0.

Reset
REQ-028 On rst_ni low, asynchronously: pointer=port 0, FSM=IDLE, counter=0, all rvalid/clr_busy_o/clr_done_o=0, rdata outputs=0.
REQ-029 Reset asserted mid-clear SHALL abort the clear with no clr_done_o pulse; a pending read response SHALL be dropped.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold ADDR_W/DATA_W defaults, DEPTH=2^ADDR_W and the clear-state enum (IDLE, CLEAR).
REQ-031 The clear FSM plus counter SHALL be a sub-module dmem_clear_engine (inputs start and issue, outputs busy, done, addr, want).

Verification
REQ-032 m0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> m0_rvalid_o one cycle after grant, m0_rdata_o=0xDEADBEEF.
REQ-033 m0 and m1 request continuously from reset -> grants alternate m0,m1,m0,m1...; each read response on the correct port only.
REQ-034 Fill memory with 0xA5A5A5A5, pulse clr_start_i with no traffic -> clr_busy_o 256 cycles, clr_done_o once, all 256 words read back 0.
REQ-035 Clear running, m1 requests every other cycle -> clear completes after 256 issued writes, m1 never stalled, clr_done_o exactly once.
REQ-036 rst_ni low at clear counter=0x80 -> clr_busy_o=0 immediately, no clr_done_o; new clr_start_i restarts from address 0.
REQ-037 clr_start_i pulsed again while busy -> ignored; exactly 256 clear writes and one done pulse.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Default geometry and the clear-engine state encoding.
package dmem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/dmem_clear_engine.sv
// Zero-fill sequencer: walks every word address once,
// advancing only when the arbiter actually issues its write.
module dmem_clear_engine
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              issue_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              want_o
);

   localparam logic [ADDR_W-1:0] LAST = '1;

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            // start_i is deliberately not looked at here
            if (issue_i) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q == CLEAR);
   assign want_o = (state_q == CLEAR);
   assign done_o = done_q;
   assign addr_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared data memory,
// with a background zero-fill that only uses idle cycles.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   input  logic              clr_start_i,
   output logic              clr_busy_o,
   output logic              clr_done_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wr_dt_o,
   output logic              mem_wr_en_o,
   input  logic [DATA_W-1:0] mem_rd_dt_i
);

   logic              ptr_q, ptr_d;
   logic              sel0, sel1;
   logic              clr_issue, clr_want;
   logic [ADDR_W-1:0] clr_addr;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   dmem_clear_engine #(
      .ADDR_W (ADDR_W)
   ) u_clr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (clr_start_i),
      .issue_i (clr_issue),
      .busy_o  (clr_busy_o),
      .done_o  (clr_done_o),
      .addr_o  (clr_addr),
      .want_o  (clr_want)
   );

   // ptr_q == 0 means port 0 wins a tie
   always_comb begin
      sel0      = m0_req_i & (~m1_req_i | ~ptr_q);
      sel1      = m1_req_i & ~sel0;
      clr_issue = clr_want & ~m0_req_i & ~m1_req_i;
      ptr_d     = ptr_q;
      if (sel0) begin
         ptr_d = 1'b1;
      end else if (sel1) begin
         ptr_d = 1'b0;
      end
   end

   always_comb begin
      mem_addr_o  = '0;
      mem_wr_dt_o = '0;
      mem_wr_en_o = 1'b0;
      unique case (1'b1)
         sel0: begin
            mem_addr_o  = m0_addr_i;
            mem_wr_dt_o = m0_wdata_i;
            mem_wr_en_o = m0_we_i;
         end
         sel1: begin
            mem_addr_o  = m1_addr_i;
            mem_wr_dt_o = m1_wdata_i;
            mem_wr_en_o = m1_we_i;
         end
         clr_issue: begin
            mem_addr_o  = clr_addr;
            mem_wr_en_o = 1'b1;
         end
         default: begin
            mem_addr_o  = '0;
         end
      endcase
   end

   always_comb begin
      rvalid0_d = sel0 & ~m0_we_i;
      rvalid1_d = sel1 & ~m1_we_i;
      rdata0_d  = rvalid0_d ? mem_rd_dt_i : rdata0_q;
      rdata1_d  = rvalid1_d ? mem_rd_dt_i : rdata1_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q     <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         ptr_q     <= ptr_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign m0_gnt_o    = sel0;
   assign m1_gnt_o    = sel1;
   assign m0_rvalid_o = rvalid0_q;
   assign m1_rvalid_o = rvalid1_q;
   assign m0_rdata_o  = rdata0_q;
   assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, cycle model of
// arbitration and clear, and a read-response scoreboard.
module tb_dmem_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          m0_req = 1'b0, m0_we = 1'b0;
   logic [AW-1:0] m0_addr = '0;
   logic [DW-1:0] m0_wdata = '0;
   logic          m0_gnt, m0_rvalid;
   logic [DW-1:0] m0_rdata;
   logic          m1_req = 1'b0, m1_we = 1'b0;
   logic [AW-1:0] m1_addr = '0;
   logic [DW-1:0] m1_wdata = '0;
   logic          m1_gnt, m1_rvalid;
   logic [DW-1:0] m1_rdata;
   logic          clr_start = 1'b0;
   logic          clr_busy, clr_done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wr_dt, mem_rd_dt;
   logic          mem_wr_en;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .m0_req_i    (m0_req),
      .m0_we_i     (m0_we),
      .m0_addr_i   (m0_addr),
      .m0_wdata_i  (m0_wdata),
      .m0_gnt_o    (m0_gnt),
      .m0_rvalid_o (m0_rvalid),
      .m0_rdata_o  (m0_rdata),
      .m1_req_i    (m1_req),
      .m1_we_i     (m1_we),
      .m1_addr_i   (m1_addr),
      .m1_wdata_i  (m1_wdata),
      .m1_gnt_o    (m1_gnt),
      .m1_rvalid_o (m1_rvalid),
      .m1_rdata_o  (m1_rdata),
      .clr_start_i (clr_start),
      .clr_busy_o  (clr_busy),
      .clr_done_o  (clr_done),
      .mem_addr_o  (mem_addr),
      .mem_wr_dt_o (mem_wr_dt),
      .mem_wr_en_o (mem_wr_en),
      .mem_rd_dt_i (mem_rd_dt)
   );

   // memory fixture
   logic [DW-1:0] fmem [256];
   always @(posedge clk) if (mem_wr_en) fmem[mem_addr] <= mem_wr_dt;
   assign mem_rd_dt = fmem[mem_addr];

   // reference state
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   logic          m_ptr = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   logic          pend0 = 1'b0, pend1 = 1'b0;
   logic [AW-1:0] m_cnt = '0;
   logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
   int            n_checks = 0;
   int            n_fail = 0;
   int            done_seen = 0;
   int            clr_wr_seen = 0;

   always @(negedge clk) begin : mon
      logic          eg0, eg1, eiss, ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      if (!rst_n) begin
         n_checks++;
         if (clr_busy !== 1'b0 || clr_done !== 1'b0 || m0_rvalid !== 1'b0 ||
             m1_rvalid !== 1'b0 || m0_rdata !== '0 || m1_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b rv0=%b rv1=%b rd0=%h rd1=%h, want all 0",
                     clr_busy, clr_done, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
         end
         m_ptr = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = '0;
         pend0 = 1'b0; pend1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
         q0.delete(); q1.delete();
      end else begin
         if (pend0) m_rd0 = q0.pop_front();
         if (pend1) m_rd1 = q1.pop_front();
         n_checks++;
         if (m0_rvalid !== pend0 || m0_rdata !== m_rd0) begin
            n_fail++;
            $display("FAIL rsp_port0 @%0t: got rv=%b rd=%h, want rv=%b rd=%h",
                     $time, m0_rvalid, m0_rdata, pend0, m_rd0);
         end
         n_checks++;
         if (m1_rvalid !== pend1 || m1_rdata !== m_rd1) begin
            n_fail++;
            $display("FAIL rsp_port1 @%0t: got rv=%b rd=%h, want rv=%b rd=%h",
                     $time, m1_rvalid, m1_rdata, pend1, m_rd1);
         end
         eg0  = m0_req && (!m1_req || !m_ptr);
         eg1  = m1_req && !eg0;
         eiss = m_busy && !m0_req && !m1_req;
         n_checks++;
         if (m0_gnt !== eg0 || m1_gnt !== eg1) begin
            n_fail++;
            $display("FAIL grant @%0t: got g0=%b g1=%b, want g0=%b g1=%b",
                     $time, m0_gnt, m1_gnt, eg0, eg1);
         end
         n_checks++;
         if (clr_busy !== m_busy || clr_done !== m_done) begin
            n_fail++;
            $display("FAIL clr_status @%0t: got busy=%b done=%b, want busy=%b done=%b",
                     $time, clr_busy, clr_done, m_busy, m_done);
         end
         ea = '0; ed = '0; ew = 1'b0;
         if (eg0) begin
            ea = m0_addr; ed = m0_wdata; ew = m0_we;
         end else if (eg1) begin
            ea = m1_addr; ed = m1_wdata; ew = m1_we;
         end else if (eiss) begin
            ea = m_cnt; ed = '0; ew = 1'b1;
         end
         n_checks++;
         if (mem_addr !== ea || mem_wr_en !== ew ||
             ((ew || !(eg0 || eg1)) && mem_wr_dt !== ed)) begin
            n_fail++;
            $display("FAIL mem_bus @%0t: got a=%h we=%b d=%h, want a=%h we=%b d=%h",
                     $time, mem_addr, mem_wr_en, mem_wr_dt, ea, ew, ed);
         end
         pend0 = eg0 && !m0_we;
         pend1 = eg1 && !m1_we;
         if (pend0) q0.push_back(ref_mem[m0_addr]);
         if (pend1) q1.push_back(ref_mem[m1_addr]);
         if (eg0 && m0_we) ref_mem[m0_addr] = m0_wdata;
         if (eg1 && m1_we) ref_mem[m1_addr] = m1_wdata;
         if (eg0) m_ptr = 1'b1;
         else if (eg1) m_ptr = 1'b0;
         m_done = 1'b0;
         if (eiss) begin
            ref_mem[m_cnt] = '0;
            if (m_cnt == 8'hFF) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
            m_cnt = m_cnt + 8'd1;
         end else if (clr_start && !m_busy) begin
            m_busy = 1'b1;
            m_cnt  = '0;
         end
         if (clr_done) done_seen++;
         if (mem_wr_en && !m0_gnt && !m1_gnt) clr_wr_seen++;
      end
   end

   // drivers: called and return at posedge+1
   task automatic m0_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int t;
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
      t = 0;
      @(negedge clk);
      while (!m0_gnt && t < 50) begin
         t++;
         @(negedge clk);
      end
      n_checks++;
      if (!m0_gnt) begin
         n_fail++;
         $display("FAIL m0_grant_timeout: got gnt=0 after %0d cycles, want 1", t);
      end
      @(posedge clk); #1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
   endtask

   task automatic m1_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int t;
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
      t = 0;
      @(negedge clk);
      while (!m1_gnt && t < 50) begin
         t++;
         @(negedge clk);
      end
      n_checks++;
      if (!m1_gnt) begin
         n_fail++;
         $display("FAIL m1_grant_timeout: got gnt=0 after %0d cycles, want 1", t);
      end
      @(posedge clk); #1;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
   endtask

   task automatic pulse_start();
      clr_start = 1'b1;
      @(posedge clk); #1;
      clr_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({clr_busy, clr_done, m0_rvalid, m1_rvalid, mem_wr_en} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_state: got %b, want 00000",
                  {clr_busy, clr_done, m0_rvalid, m1_rvalid, mem_wr_en});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (mem_addr !== '0 || mem_wr_dt !== '0 || mem_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_bus: got a=%h d=%h we=%b, want 0", mem_addr, mem_wr_dt, mem_wr_en);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      m0_op(1'b1, 8'h10, 32'hDEADBEEF);
      m0_op(1'b0, 8'h10, '0);
      @(negedge clk);
      n_checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_rd_0x10: got rv=%b rd=%h, want rv=1 rd=deadbeef", m0_rvalid, m0_rdata);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL rdata_hold: got rv=%b rd=%h, want rv=0 rd=deadbeef", m0_rvalid, m0_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int  nrv;
      time t0, t1;
      for (int i = 0; i < 8; i++) m0_op(1'b1, 8'(8'h20 + i), 32'h1000_0000 + i);
      nrv = 0;
      fork
         begin
            t0 = $time;
            for (int i = 0; i < 8; i++) m0_op(1'b0, 8'(8'h20 + i), '0);
            t1 = $time;
         end
         begin
            repeat (12) begin
               @(negedge clk);
               if (m0_rvalid) nrv++;
            end
         end
      join
      @(posedge clk); #1;
      n_checks++;
      if (nrv != 8) begin
         n_fail++;
         $display("FAIL b2b_responses: got %0d, want 8", nrv);
      end
      n_checks++;
      if (t1 - t0 != 80) begin
         n_fail++;
         $display("FAIL b2b_throughput: got %0t, want 80", t1 - t0);
      end
   endtask

   task automatic test_round_robin();
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      fork
         for (int i = 0; i < 4; i++) m0_op(1'b0, 8'(8'h20 + i), '0);
         for (int i = 0; i < 4; i++) m1_op(1'b0, 8'(8'h24 + i), '0);
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin
               n_fail++;
               $display("FAIL rr_cycle%0d: got g0=%b g1=%b, want g0=%b g1=%b",
                        i, m0_gnt, m1_gnt, (i % 2 == 0), (i % 2 == 1));
            end
         end
      join
      @(posedge clk); #1;
   endtask

   task automatic test_clear_idle();
      int d0, w0, nbusy, nrv, nz;
      for (int i = 0; i < 256; i++) m0_op(1'b1, 8'(i), 32'hA5A5A5A5);
      d0 = done_seen; w0 = clr_wr_seen; nbusy = 0;
      pulse_start();
      repeat (300) begin
         @(negedge clk);
         if (clr_busy) nbusy++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (nbusy != 256) begin
         n_fail++;
         $display("FAIL clr_busy_cycles: got %0d, want 256", nbusy);
      end
      n_checks++;
      if (done_seen - d0 != 1 || clr_wr_seen - w0 != 256) begin
         n_fail++;
         $display("FAIL clr_idle_count: got done=%0d writes=%0d, want 1 256",
                  done_seen - d0, clr_wr_seen - w0);
      end
      nrv = 0; nz = 0;
      fork
         for (int i = 0; i < 256; i++) m0_op(1'b0, 8'(i), '0);
         repeat (258) begin
            @(negedge clk);
            if (m0_rvalid) begin
               nrv++;
               if (m0_rdata != '0) nz++;
            end
         end
      join
      @(posedge clk); #1;
      n_checks++;
      if (nrv != 256 || nz != 0) begin
         n_fail++;
         $display("FAIL clr_readback: got rsp=%0d nonzero=%0d, want 256 0", nrv, nz);
      end
   endtask

   task automatic test_clear_traffic();
      int d0, w0, stalls, k;
      for (int i = 0; i < 16; i++) m0_op(1'b1, 8'(i * 16), 32'hA5A5A5A5);
      d0 = done_seen; w0 = clr_wr_seen; stalls = 0; k = 0;
      pulse_start();
      while (done_seen == d0 && k < 700) begin
         if (k % 2 == 0) begin
            m1_req = 1'b1; m1_we = (k % 4 == 0);
            m1_addr = 8'($urandom_range(0, 255)); m1_wdata = $urandom;
         end
         @(negedge clk);
         if (m1_req && !m1_gnt) stalls++;
         @(posedge clk); #1;
         m1_req = 1'b0; m1_we = 1'b0;
         k++;
      end
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (stalls != 0) begin
         n_fail++;
         $display("FAIL m1_stalled: got %0d stalls, want 0", stalls);
      end
      n_checks++;
      if (done_seen - d0 != 1 || clr_wr_seen - w0 != 256) begin
         n_fail++;
         $display("FAIL clr_traffic_count: got done=%0d writes=%0d, want 1 256",
                  done_seen - d0, clr_wr_seen - w0);
      end
      for (int i = 0; i < 16; i++) m0_op(1'b0, 8'(i * 16), '0);
   endtask

   task automatic test_reset_mid_clear();
      int w0, d0, t;
      w0 = clr_wr_seen; t = 0;
      pulse_start();
      while (clr_wr_seen - w0 < 128 && t < 400) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (clr_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_busy: got %b, want 0", clr_busy);
      end
      d0 = done_seen;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (done_seen != d0 || clr_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_done: got done=%0d busy=%b, want 0 0", done_seen - d0, clr_busy);
      end
      w0 = clr_wr_seen; d0 = done_seen;
      pulse_start();
      @(negedge clk);
      n_checks++;
      if (mem_wr_en !== 1'b1 || mem_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL restart_addr: got we=%b a=%h, want we=1 a=00", mem_wr_en, mem_addr);
      end
      t = 0;
      while (done_seen == d0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (done_seen - d0 != 1 || clr_wr_seen - w0 != 256) begin
         n_fail++;
         $display("FAIL restart_count: got done=%0d writes=%0d, want 1 256",
                  done_seen - d0, clr_wr_seen - w0);
      end
   endtask

   task automatic test_restart_ignored();
      int w0, d0, t;
      w0 = clr_wr_seen; d0 = done_seen; t = 0;
      pulse_start();
      repeat (50) @(posedge clk);
      #1;
      pulse_start();
      while (done_seen == d0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (done_seen - d0 != 1 || clr_wr_seen - w0 != 256 || clr_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_ignored: got done=%0d writes=%0d busy=%b, want 1 256 0",
                  done_seen - d0, clr_wr_seen - w0, clr_busy);
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_round_robin();
      test_clear_idle();
      test_clear_traffic();
      test_reset_mid_clear();
      test_restart_ignored();
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
